// File: rtl/hit_judge_if.sv
// Bundles the game-state, note, button and judgment signals of the two-lane hit judge.
interface hit_judge_if;
    logic [1:0]  current_state;
    logic [1:0]  note_arrive;
    logic [1:0]  btn;
    logic [1:0]  Inp;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [1:0]  miss;
    logic [15:0] miss_count;

    modport master (
        output current_state, note_arrive, btn,
        input  Inp, combo, max_combo, miss, miss_count
    );

    modport slave (
        input  current_state, note_arrive, btn,
        output Inp, combo, max_combo, miss, miss_count
    );
endinterface

// File: rtl/hit_judge.sv
// Two-lane rhythm-game judge: per-lane hit windows, combo/max-combo and miss tracking.
//   lane state | meaning
//   WAIT       | no note pending in this lane
//   OPEN       | note in judgment zone, cnt counts remaining window cycles
module hit_judge #(
    parameter int WINDOW_LEN = 8,
    parameter int COMBO_MAX  = 255
) (
    input logic        clk,
    input logic        rst,
    hit_judge_if.slave bus
);
    localparam int            CW     = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(WINDOW_LEN - 1);
    localparam logic [8:0]    CMAX   = 9'(COMBO_MAX);
    localparam logic [1:0]    S_SEL  = 2'd1;
    localparam logic [1:0]    S_PLAY = 2'd2;

    typedef enum logic {WAIT, OPEN} lane_t;

    lane_t         lane_q [2];
    lane_t         lane_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];

    logic [1:0]  s0, s1, prev, rise;
    logic [1:0]  hit_d, miss_d;
    logic        play;
    logic [1:0]  hit_pop, miss_pop;
    logic [8:0]  combo_sum;
    logic [7:0]  combo_d, max_d;
    logic [16:0] mc_sum;
    logic [15:0] mc_d;

    logic [1:0]  inp_q, miss_q;
    logic [7:0]  combo_q, max_q;
    logic [15:0] mc_q;

    assign play = (bus.current_state == S_PLAY);
    assign rise = s1 & ~prev;

    always_comb begin
        hit_d  = '0;
        miss_d = '0;
        for (int i = 0; i < 2; i++) begin
            lane_d[i] = WAIT;
            cnt_d[i]  = cnt_q[i];
            if (play) begin
                lane_d[i] = lane_q[i];
                if (lane_q[i] == WAIT) begin
                    // a press with no note pending is simply ignored
                    if (bus.note_arrive[i]) begin
                        lane_d[i] = OPEN;
                        cnt_d[i]  = RELOAD;
                    end
                end else if (rise[i] || cnt_q[i] == '0) begin
                    hit_d[i]  = rise[i];
                    miss_d[i] = ~rise[i];
                    if (bus.note_arrive[i]) begin
                        cnt_d[i] = RELOAD;
                    end else begin
                        lane_d[i] = WAIT;
                    end
                end else if (bus.note_arrive[i]) begin
                    miss_d[i] = 1'b1;
                    cnt_d[i]  = RELOAD;
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    assign hit_pop   = {1'b0, hit_d[0]} + {1'b0, hit_d[1]};
    assign miss_pop  = {1'b0, miss_d[0]} + {1'b0, miss_d[1]};
    assign combo_sum = {1'b0, combo_q} + {7'b0, hit_pop};
    assign combo_d   = (|miss_d) ? 8'd0 : ((combo_sum > CMAX) ? CMAX[7:0] : combo_sum[7:0]);
    assign max_d     = (combo_d > max_q) ? combo_d : max_q;
    assign mc_sum    = {1'b0, mc_q} + {15'b0, miss_pop};
    assign mc_d      = mc_sum[16] ? 16'hFFFF : mc_sum[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0      <= '0;
            s1      <= '0;
            prev    <= '0;
            inp_q   <= '0;
            miss_q  <= '0;
            combo_q <= '0;
            max_q   <= '0;
            mc_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                lane_q[i] <= WAIT;
                cnt_q[i]  <= '0;
            end
        end else begin
            s0     <= bus.btn;
            s1     <= s0;
            prev   <= s1;
            inp_q  <= hit_d;
            miss_q <= miss_d;
            for (int i = 0; i < 2; i++) begin
                lane_q[i] <= lane_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            if (play) begin
                combo_q <= combo_d;
                max_q   <= max_d;
                mc_q    <= mc_d;
            end else if (bus.current_state == S_SEL) begin
                combo_q <= '0;
                max_q   <= '0;
                mc_q    <= '0;
            end
        end
    end

    assign bus.Inp        = inp_q;
    assign bus.miss       = miss_q;
    assign bus.combo      = combo_q;
    assign bus.max_combo  = max_q;
    assign bus.miss_count = mc_q;
endmodule
